// File: rtl/mux_rr_pkg.sv
// Shared types and helpers for the N:1 registered channel mux.
package mux_rr_pkg;

   typedef enum logic {
      MODE_SEL = 1'b0,
      MODE_RR  = 1'b1
   } mux_mode_e;

   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority search: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_vld,
   output logic [SEL_W-1:0] gnt_idx
);

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      // Walk from farthest to nearest so the lowest offset from ptr wins.
      for (int i = N - 1; i >= 0; i--) begin
         logic [SEL_W-1:0] cand;
         cand = SEL_W'((int'(ptr) + i) % N);
         if (req[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_reg.sv
// N:1 valid/ready channel mux with explicit-select or round-robin grant and a registered output.
module mux_rr_reg
   import mux_rr_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 8,
   localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             mode_i,
   input  logic [SEL_W-1:0] sel_i,
   input  logic [N-1:0]     valid_i,
   input  logic [N*WIDTH-1:0] data_i,
   output logic [N-1:0]     ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o,
   output logic [SEL_W-1:0] chan_o,
   input  logic             ready_i
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SEL_W-1:0] chan_q, chan_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic             rr_vld;
   logic [SEL_W-1:0] rr_idx;
   logic             sel_vld;
   logic             gnt_vld;
   logic [SEL_W-1:0] gnt_idx;
   logic             load_en;
   logic             xfer;
   mux_mode_e        mode;

   rr_arbiter #(.N(N)) u_arb (
      .req     (valid_i),
      .ptr     (rr_ptr_q),
      .gnt_vld (rr_vld),
      .gnt_idx (rr_idx)
   );

   always_comb begin
      mode    = mux_mode_e'(mode_i);
      load_en = !valid_q || ready_i;

      sel_vld = 1'b0;
      if (int'(sel_i) < N) sel_vld = valid_i[sel_i];

      if (mode == MODE_RR) begin
         gnt_vld = rr_vld;
         gnt_idx = rr_idx;
      end else begin
         gnt_vld = sel_vld;
         gnt_idx = sel_i;
      end

      xfer = gnt_vld && load_en;

      // Gated by reset_n so no producer sees a handshake while reset is asserted.
      ready_o = '0;
      if (xfer && reset_n) ready_o[gnt_idx] = 1'b1;

      valid_d  = valid_q;
      data_d   = data_q;
      chan_d   = chan_q;
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         valid_d = 1'b1;
         data_d  = data_i[int'(gnt_idx)*WIDTH +: WIDTH];
         chan_d  = gnt_idx;
         if (mode == MODE_RR) rr_ptr_d = SEL_W'(rr_next(int'(gnt_idx), N));
      end else if (load_en) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         chan_q   <= '0;
         rr_ptr_q <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         chan_q   <= chan_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign chan_o  = chan_q;

endmodule
